wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_watchdog.sv | 40 ++++
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the two-initiator Wishbone arbiter.
// Arbiter state encoding, initiator index type and watchdog counter width.
package wb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  // Index of a bus initiator (0 = MCU/SPI bridge, 1 = video fetch).
  typedef logic init_idx_t;

  // Width of the no-ack watchdog counter.
  localparam int unsigned WDOG_WIDTH = 8;

endpackage

// File: rtl/wb_watchdog.sv
// No-ack watchdog for the arbiter. Counts granted cycles that pass without a
// target ack; 'expired' rises combinationally in the TIMEOUT_CYCLES-th such
// cycle so the arbiter can release the bus in that same cycle.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic wb_clock_i,
  input  logic wb_reset_ni,
  input  logic start,
  input  logic ack,
  input  logic active,
  output logic expired
);

  localparam logic [WDOG_WIDTH-1:0] LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_WIDTH-1:0] SAT   = '1;

  logic [WDOG_WIDTH-1:0] count_reg;

  // count_reg holds the silent cycles seen before the current one
  assign expired = active && !ack && (count_reg >= LIMIT);

  // Clear on a fresh grant or on any ack, otherwise count silent cycles and saturate
  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= '0;
    end else if (active) begin
      if (ack) begin
        count_reg <= '0;
      end else if (count_reg != SAT) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-initiator Wishbone B4 pipelined arbiter with round-robin tie breaking.
// Optional no-ack watchdog is enabled by defining WB_ARBITER_TIMEOUT_EN;
// without it a tenure ends only when the owner drops cyc.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_ni,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0]    m0_data_i,
  output logic [DATA_WIDTH-1:0]    m0_data_o,
  output logic                     m0_stall_o,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0]    m1_data_i,
  output logic [DATA_WIDTH-1:0]    m1_data_o,
  output logic                     m1_stall_o,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0]    s_data_o,
  input  logic [DATA_WIDTH-1:0]    s_data_i,
  input  logic                     s_stall_i,
  input  logic                     s_ack_i,
  output logic [1:0]               grant_o,
  output logic                     timeout_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  arb_state_e state_reg, state_next;
  init_idx_t  last_served_reg, last_served_next;
  logic       owner_cyc;
  logic       expired;

  // cyc of whichever initiator currently owns the bus
  always_comb begin
    owner_cyc = 1'b0;
    if (state_reg == ARB_GRANT0) owner_cyc = m0_cyc_i;
    if (state_reg == ARB_GRANT1) owner_cyc = m1_cyc_i;
  end

  // Arbitration: grant from IDLE only, so every tenure is followed by one idle cycle
  always_comb begin
    state_next       = state_reg;
    last_served_next = last_served_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_next       = (last_served_reg == 1'b0) ? ARB_GRANT1 : ARB_GRANT0;
          last_served_next = (last_served_reg == 1'b0) ? 1'b1 : 1'b0;
        end else if (m0_cyc_i) begin
          state_next       = ARB_GRANT0;
          last_served_next = 1'b0;
        end else if (m1_cyc_i) begin
          state_next       = ARB_GRANT1;
          last_served_next = 1'b1;
        end
      end
      ARB_GRANT0: if (!m0_cyc_i || expired) state_next = ARB_IDLE;
      ARB_GRANT1: if (!m1_cyc_i || expired) state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // State and round-robin history; reset favours initiator 0 on the first tie
  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_reg       <= ARB_IDLE;
      last_served_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      last_served_reg <= last_served_next;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  logic grant_start;
  assign grant_start = (state_reg == ARB_IDLE) && (state_next != ARB_IDLE);

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .wb_clock_i (wb_clock_i),
    .wb_reset_ni(wb_reset_ni),
    .start      (grant_start),
    .ack        (s_ack_i),
    .active     (owner_cyc),
    .expired    (expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign timeout_o = expired;

  // Route the owner's request to the target and the target's response back to the owner
  always_comb begin
    grant_o    = 2'b00;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_data_o   = '0;
    m0_data_o  = '0;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_data_o  = '0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    case (state_reg)
      ARB_GRANT0: begin
        grant_o    = 2'b01;
        s_cyc_o    = m0_cyc_i && !expired;
        s_stb_o    = m0_stb_i && !expired;
        s_we_o     = m0_we_i;
        s_addr_o   = m0_addr_i;
        s_data_o   = m0_data_i;
        m0_data_o  = s_data_i;
        m0_stall_o = s_stall_i;
        m0_ack_o   = s_ack_i;
        m0_err_o   = expired;
      end
      ARB_GRANT1: begin
        grant_o    = 2'b10;
        s_cyc_o    = m1_cyc_i && !expired;
        s_stb_o    = m1_stb_i && !expired;
        s_we_o     = m1_we_i;
        s_addr_o   = m1_addr_i;
        s_data_o   = m1_data_i;
        m1_data_o  = s_data_i;
        m1_stall_o = s_stall_i;
        m1_ack_o   = s_ack_i;
        m1_err_o   = expired;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised scoreboard bench for wb_arbiter. The driver advances a
// tenure-level reference model each clock and queues the outputs it expects;
// a monitor on the falling edge pops and compares them.
module tb_wb_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int TO = 4;
`ifdef WB_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]         grant;
    logic               s_cyc;
    logic               s_stb;
    logic               s_we;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_data;
    logic [1:0]         m_stall;
    logic [1:0]         m_ack;
    logic [1:0]         m_err;
    logic [1:0][DW-1:0] m_rdata;
    logic               timeout;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] s_rdata = '0;
  logic          s_stall = 1'b0, s_ack = 1'b0;

  logic [DW-1:0] m0_data, m1_data, s_data;
  logic          m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, timeout;
  logic [AW-1:0] s_addr;
  logic [1:0]    grant;

  wb_arbiter #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clock_i(clk), .wb_reset_ni(rst_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_wdata[0]),
    .m0_data_o(m0_data), .m0_stall_o(m0_stall), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_wdata[1]),
    .m1_data_o(m1_data), .m1_stall_o(m1_stall), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_data),
    .s_data_i(s_rdata), .s_stall_i(s_stall), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, who was served last, silent cycles so far
  int   owner = -1, last = 1, quiet = 0, ten_len = 0, ten_acks = 0;
  obs_t exp_q[$];
  int   checks = 0, passed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: actual 0x%0h required 0x%0h", name, $time, act, exp);
  endtask

  function automatic bit timeout_now();
    return TO_EN && owner >= 0 && m_cyc[owner] && !s_ack && (quiet + 1 >= TO);
  endfunction

  function automatic obs_t predict();
    obs_t e;
    bit   to;
    e = '0;
    e.m_stall = 2'b11;
    if (!rst_n || owner < 0) return e;
    to             = timeout_now();
    e.grant        = 2'b01 << owner;
    e.s_cyc        = m_cyc[owner] && !to;
    e.s_stb        = m_stb[owner] && !to;
    e.s_we         = m_we[owner];
    e.s_addr       = m_addr[owner];
    e.s_data       = m_wdata[owner];
    e.m_stall[owner] = s_stall;
    e.m_ack[owner]   = s_ack;
    e.m_err[owner]   = to;
    e.m_rdata[owner] = s_rdata;
    e.timeout      = to;
    return e;
  endfunction

  task automatic model_reset();
    if (owner >= 0) $display("tenure m%0d aborted by reset after %0d cycles", owner, ten_len);
    owner = -1; last = 1; quiet = 0;
  endtask

  // Apply the rising edge to the model using the inputs that were present at it
  task automatic advance();
    bit to;
    if (!rst_n) return;
    if (owner < 0) begin
      if (m_cyc == 2'b11) owner = 1 - last;
      else if (m_cyc[0])  owner = 0;
      else if (m_cyc[1])  owner = 1;
      if (owner >= 0) begin
        last = owner; quiet = 0; ten_len = 0; ten_acks = 0;
      end
    end else begin
      to = timeout_now();
      ten_len++;
      if (s_ack) ten_acks++;
      if (!m_cyc[owner] || to) begin
        $display("tenure m%0d: %0d cycles, %0d acks%s", owner, ten_len, ten_acks,
                 to ? ", forced release" : "");
        owner = -1;
      end else if (s_ack) quiet = 0;
      else if (quiet < 255) quiet++;
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic publish();
    exp_q.push_back(predict());
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_stall = 1'b0;
  endtask

  task automatic do_reset();
    cyc_begin();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    publish();
    cyc_begin();
    rst_n = 1'b1;
    publish();
  endtask

  // Monitor: compare the DUT against the queued expectation every falling edge
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", 64'(grant), 64'(e.grant));
        chk("target_req", 64'({s_cyc, s_stb, s_we, s_addr, s_data}),
            64'({e.s_cyc, e.s_stb, e.s_we, e.s_addr, e.s_data}));
        chk("m0_resp", 64'({m0_stall, m0_ack, m0_err, e.m_ack[0] ? m0_data : 8'h00}),
            64'({e.m_stall[0], e.m_ack[0], e.m_err[0], e.m_ack[0] ? e.m_rdata[0] : 8'h00}));
        chk("m1_resp", 64'({m1_stall, m1_ack, m1_err, e.m_ack[1] ? m1_data : 8'h00}),
            64'({e.m_stall[1], e.m_ack[1], e.m_err[1], e.m_ack[1] ? e.m_rdata[1] : 8'h00}));
        chk("timeout", 64'(timeout), 64'(e.timeout));
      end
    end
  end

  logic [1:0] seq034 [8];
  int         len [2];
  int         xf [2];
  bit         drop [2];
  int         gcnt [2];
  logic [1:0] prev_g;
  int         tcnt, errs, lost;

  initial begin
    m_addr[0] = '0; m_addr[1] = '0; m_wdata[0] = '0; m_wdata[1] = '0;
    seq034 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

    // Reset held with both initiators requesting: outputs must stay idle
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      m_cyc = 2'b11; s_ack = 1'b1;
      publish();
    end

    // Lone m0 write to 0x08000; m0 is picked on the first edge after release
    cyc_begin();
    idle_inputs();
    rst_n = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_addr[0] = 20'h08000; m_wdata[0] = 8'hA5; s_stall = 1'b1;
    publish();
    cyc_begin();
    s_stall = 1'b0;
    publish();
    #2;
    chk("req033_grant", 64'(grant), 64'(2'b01));
    chk("req033_addr", 64'(s_addr), 64'(20'h08000));
    chk("req033_m1_stall", 64'(m1_stall), 64'(1));
    cyc_begin();
    m_stb[0] = 1'b0; s_ack = 1'b1; s_rdata = 8'h3C;
    publish();
    #2;
    chk("req033_ack", 64'(m0_ack), 64'(1));
    cyc_begin();
    m_cyc[0] = 1'b0; s_ack = 1'b0;
    publish();

    // Simultaneous request after reset: m0 first, one idle cycle, then m1
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc_begin();
      m_cyc = {1'(k < 6), 1'(k < 3)}; m_stb = m_cyc; s_ack = 1'b1;
      publish();
      #2;
      chk($sformatf("req034_grant_k%0d", k), 64'(grant), 64'(seq034[k]));
    end

    // Both keep coming back for 3-transfer tenures: grants must alternate
    idle_inputs();
    s_ack = 1'b1;
    xf = '{0, 0}; drop = '{0, 0}; gcnt = '{0, 0}; prev_g = 2'b00;
    for (int k = 0; k < 40; k++) begin
      cyc_begin();
      for (int n = 0; n < 2; n++) begin
        if (drop[n]) begin m_cyc[n] = 1'b0; drop[n] = 1'b0; end
        else m_cyc[n] = 1'b1;
        if (owner == n && m_cyc[n]) begin
          xf[n]++;
          if (xf[n] == 3) begin drop[n] = 1'b1; xf[n] = 0; end
        end
      end
      m_stb = m_cyc;
      publish();
      #2;
      if (prev_g == 2'b00 && grant == 2'b01) gcnt[0]++;
      if (prev_g == 2'b00 && grant == 2'b10) gcnt[1]++;
      prev_g = grant;
    end
    chk("req035_m0_served", 64'(gcnt[0] >= 3), 64'(1));
    chk("req035_m1_served", 64'(gcnt[1] >= 3), 64'(1));

    // m1 never acked while m0 waits
    do_reset();
    tcnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc_begin();
      m_cyc = {1'b1, 1'(k >= 1)}; m_stb = m_cyc; s_ack = 1'b0; s_stall = 1'b1;
      publish();
      #2;
      if (timeout) tcnt++;
      if (k == 4) begin
        chk("req036_timeout_k4", 64'(timeout), 64'(TO_EN));
        chk("req036_m1_err_k4", 64'(m1_err), 64'(TO_EN));
        chk("req036_s_cyc_k4", 64'(s_cyc), 64'(!TO_EN));
      end
    end
    chk("req036_pulses", 64'(tcnt), 64'(TO_EN ? 1 : 0));
    chk("req036_final_grant", 64'(grant), 64'(TO_EN ? 2'b01 : 2'b10));

    // Reset in the middle of an m1 read; the target acks as reset hits
    do_reset();
    cyc_begin();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 20'h1234A;
    publish();
    cyc_begin();
    publish();
    cyc_begin();
    s_ack = 1'b1; s_rdata = 8'h5A;
    rst_n = 1'b0;
    model_reset();
    publish();
    #2;
    chk("req037_grant", 64'(grant), 64'(2'b00));
    chk("req037_s_cyc", 64'(s_cyc), 64'(0));
    chk("req037_m1_ack", 64'(m1_ack), 64'(0));
    cyc_begin();
    rst_n = 1'b1; s_ack = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    publish();
    cyc_begin();
    publish();
    #2;
    chk("req037_tie_to_m0", 64'(grant), 64'(2'b01));

    // Long stall on m1
    do_reset();
    errs = 0; lost = 0;
    for (int k = 0; k < 302; k++) begin
      cyc_begin();
      m_cyc = 2'b10; m_stb = 2'b10; s_stall = 1'b1; s_ack = 1'b0;
      publish();
      #2;
      if (m1_err || timeout) errs++;
      if (k >= 1 && grant != 2'b10) lost++;
    end
    cyc_begin();
    m_stb = 2'b00; s_stall = 1'b0; s_ack = 1'b1;
    publish();
`ifndef WB_ARBITER_TIMEOUT_EN
    #2;
    chk("req038_ack", 64'(m1_ack), 64'(1));
    chk("req038_no_err", 64'(errs), 64'(0));
    chk("req038_grant_held", 64'(lost), 64'(0));
`endif
    cyc_begin();
    idle_inputs();
    publish();

    // Random traffic against the model
    len = '{0, 0};
    for (int i = 0; i < 1500; i++) begin
      cyc_begin();
      for (int n = 0; n < 2; n++) begin
        if (len[n] == 0) begin
          m_cyc[n] = ($urandom_range(0, 2) != 0);
          len[n]   = $urandom_range(1, 8);
        end else len[n]--;
        m_stb[n]   = m_cyc[n] & 1'($urandom);
        m_we[n]    = 1'($urandom);
        m_addr[n]  = AW'($urandom);
        m_wdata[n] = DW'($urandom);
      end
      s_ack   = ((i % 64) < 48) && ($urandom_range(0, 9) < 4);
      s_stall = ($urandom_range(0, 3) == 0);
      s_rdata = DW'($urandom);
      publish();
    end

    cyc_begin();
    idle_inputs();
    publish();
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
